// File: rtl/definitions.sv
// Shared constants and types for the fetch/decode slice.
package definitions;
  localparam int PC_W_DEF       = 10;
  localparam int IMEM_DEPTH_DEF = 1024;
  localparam int CNT_W_DEF      = 16;

  // Opcode field values seen by the control decoder downstream.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_BR   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {FS_IDLE, FS_ARM, FS_RUN, FS_HALT} fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                        count_q <= '0;
    else if (clr)                     count_q <= '0;
    else if (inc && (count_q != '1))  count_q <= count_q + W'(1);
  end

  assign count = count_q;
endmodule

// File: rtl/instr_fetch.sv
// PC register and fetch sequencer: Start/Done handshake, branch/stop
// resolution, end-of-memory fault detection and profiling counters.
module instr_fetch
  import definitions::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stop,
  input  logic             BranchEn,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  InstrAddr,
  output logic             FetchEn,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] BranchCount
);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);
  localparam logic [PC_W:0]   DEPTH_X = (PC_W + 1)'(IMEM_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d, fault_q, fault_d;
  logic            cyc_inc, br_inc;
  logic            tgt_oob;

  // Only reachable when the memory is smaller than the PC address space.
  assign tgt_oob = ({1'b0, Target} >= DEPTH_X);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    fault_d = fault_q;
    cyc_inc = 1'b0;
    br_inc  = 1'b0;
    if (Start) begin
      state_d = FS_ARM;
      pc_d    = StartAddr;
      done_d  = 1'b0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        FS_ARM: state_d = FS_RUN;
        FS_RUN: begin
          cyc_inc = 1'b1;
          if (Stop) begin
            state_d = FS_HALT;
            done_d  = 1'b1;
          end else if (BranchEn) begin
            if (tgt_oob) begin
              state_d = FS_HALT;
              done_d  = 1'b1;
              fault_d = 1'b1;
            end else begin
              pc_d   = Target;
              br_inc = 1'b1;
            end
          end else if (pc_q == LAST_PC) begin
            state_d = FS_HALT;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .Clk(Clk), .Reset(Reset), .clr(Start), .inc(cyc_inc), .count(CycleCount)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .Clk(Clk), .Reset(Reset), .clr(Start), .inc(br_inc), .count(BranchCount)
  );

  assign InstrAddr = pc_q;
  assign FetchEn   = (state_q == FS_RUN);
  assign Done      = done_q;
  assign Fault     = fault_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a behavioural model;
// a second instance with 4-bit counters shares all inputs.
module tb_instr_fetch;
  localparam int PC_W  = 10;
  localparam int DEPTH = 1024;
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_HALT = 3;

  logic            Clk = 1'b0;
  logic            Reset, Start, Stop, BranchEn;
  logic [PC_W-1:0] StartAddr, Target;
  logic [PC_W-1:0] InstrAddr, InstrAddr4;
  logic            FetchEn, Done, Fault, FetchEn4, Done4, Fault4;
  logic [15:0]     CycleCount, BranchCount;
  logic [3:0]      CycleCount4, BranchCount4;

  always #5 Clk = ~Clk;

  instr_fetch #(.PC_W(PC_W), .IMEM_DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stop(Stop), .BranchEn(BranchEn), .Target(Target),
    .InstrAddr(InstrAddr), .FetchEn(FetchEn), .Done(Done), .Fault(Fault),
    .CycleCount(CycleCount), .BranchCount(BranchCount)
  );

  instr_fetch #(.PC_W(PC_W), .IMEM_DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stop(Stop), .BranchEn(BranchEn), .Target(Target),
    .InstrAddr(InstrAddr4), .FetchEn(FetchEn4), .Done(Done4), .Fault(Fault4),
    .CycleCount(CycleCount4), .BranchCount(BranchCount4)
  );

  int nvec, nerr;
  int m_mode, m_pc, m_cyc, m_br;
  bit m_done, m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all();
    chk("pc",     InstrAddr,    m_pc);
    chk("fetch",  FetchEn,      (m_mode == M_RUN));
    chk("done",   Done,         m_done);
    chk("fault",  Fault,        m_fault);
    chk("cyc",    CycleCount,   sat(m_cyc, 65535));
    chk("br",     BranchCount,  sat(m_br, 65535));
    chk("pc4",    InstrAddr4,   m_pc);
    chk("cyc4",   CycleCount4,  sat(m_cyc, 15));
    chk("br4",    BranchCount4, sat(m_br, 15));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_cyc = 0; m_br = 0; m_done = 0; m_fault = 0;
  endtask

  // One clock of the specified behaviour, from the inputs presented before the edge.
  task automatic model_step();
    if (Start) begin
      m_mode = M_ARM; m_pc = int'(StartAddr);
      m_done = 0; m_fault = 0; m_cyc = 0; m_br = 0;
    end else if (m_mode == M_ARM) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_cyc++;
      if (Stop) begin
        m_mode = M_HALT; m_done = 1;
      end else if (BranchEn) begin
        if (int'(Target) >= DEPTH) begin
          m_mode = M_HALT; m_done = 1; m_fault = 1;
        end else begin
          m_pc = int'(Target); m_br++;
        end
      end else if (m_pc == DEPTH - 1) begin
        m_mode = M_HALT; m_done = 1; m_fault = 1;
      end else begin
        m_pc++;
      end
    end
  endtask

  task automatic cyc(input bit st, input int sa, input bit sp, input bit be, input int tg);
    Start = st; StartAddr = PC_W'(sa); Stop = sp; BranchEn = be; Target = PC_W'(tg);
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    Reset = 1'b1; Start = 0; Stop = 0; BranchEn = 0; StartAddr = '0; Target = '0;
    model_reset();
    #12;
    check_all();
    Reset = 1'b0;

    // Launch at 5: three armed cycles, then free-running fetch
    repeat (3) cyc(1, 5, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);

    // Branch then stop with a simultaneous branch
    cyc(1, 10, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3);
    chk("br_taken_pc", InstrAddr, 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 7);
    chk("stop_pc", InstrAddr, 4);
    chk("stop_br", BranchCount, 1);
    repeat (3) cyc(0, 0, 1, 1, 9);

    // Run off the end of memory
    cyc(1, DEPTH - 2, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    chk("end_fault", Fault, 1);
    chk("end_cyc", CycleCount, 2);

    // Restart from HALT
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);

    // 4-bit counter saturation
    cyc(1, 100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, ($urandom_range(0, 1) == 0), 200);
    chk("cyc4_sat", CycleCount4, 15);

    // Asynchronous reset mid-RUN at PC=37
    cyc(1, 30, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0);
    chk("pre_rst_pc", InstrAddr, 37);
    reset_pulse();
    cyc(0, 0, 1, 1, 5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) reset_pulse();
      else cyc(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(DEPTH - 24, DEPTH - 1))
                                           : int'($urandom_range(0, DEPTH - 1)),
               ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, DEPTH - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
